// File: rtl/inst_cache_nway_if.sv
// ============================================================================
// Module   : inst_cache_nway_if
// Brief    : Fetch-side and memory-side bus bundle for inst_cache_nway.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_cache_nway_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic              flush;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              stall;
  logic              cache_hit;
  logic              err;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_stall;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output rd, wr, addr, flush, mem_stall, mem_rvalid, mem_rdata,
    input  data_out, done, stall, cache_hit, err, mem_rd, mem_addr
  );

  modport slave (
    input  rd, wr, addr, flush, mem_stall, mem_rvalid, mem_rdata,
    output data_out, done, stall, cache_hit, err, mem_rd, mem_addr
  );
endinterface

`default_nettype wire

// File: rtl/inst_cache_nway.sv
// ============================================================================
// Module   : inst_cache_nway
// Brief    : Read-only N-way set-associative instruction cache controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_cache_nway #(
  parameter int WAYS   = 2,
  parameter int SETS   = 256,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  inst_cache_nway_if.slave bus
);

  localparam int WORD_W = $clog2(WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - WORD_W - 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W  = WORD_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-2:0] req_q, req_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic              evict_q, evict_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  resp_cnt_q, resp_cnt_d;
  logic [IDX_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              cache_hit_q, cache_hit_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_mem [WAYS][SETS];
  logic [DATA_W-1:0] data_mem[WAYS][SETS][WORDS];

  // Word-address view: IDLE looks up the live fetch address, later states the latched one.
  logic [ADDR_W-2:0] cur;
  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;

  assign cur  = (state_q == S_IDLE) ? bus.addr[ADDR_W-1:1] : req_q;
  assign word = cur[WORD_W-1:0];
  assign idx  = cur[WORD_W+IDX_W-1:WORD_W];
  assign tag  = cur[ADDR_W-2:WORD_W+IDX_W];

  logic [WAYS-1:0] hit_vec;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign hit_vec[w] = valid_q[idx][w] && (tag_mem[w][idx] == tag);
  end

  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] free_way;
  logic             has_free;

  always_comb begin
    hit_way  = '0;
    free_way = '0;
    has_free = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (!valid_q[idx][w]) begin
        free_way = WAY_W'(w);
        has_free = 1'b1;
      end
    end
  end

  logic [WAY_W-1:0] rr_next;
  assign rr_next = (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;

  logic done, stall, err, out_en, mem_rd, fill_we, line_done, flush_clr;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    victim_d     = victim_q;
    evict_d      = evict_q;
    issue_cnt_d  = issue_cnt_q;
    resp_cnt_d   = resp_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    flush_pend_d = flush_pend_q;
    cache_hit_d  = 1'b0;
    done         = 1'b0;
    stall        = 1'b0;
    err          = 1'b0;
    out_en       = 1'b0;
    mem_rd       = 1'b0;
    fill_we      = 1'b0;
    line_done    = 1'b0;
    flush_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.flush || flush_pend_q) begin
          stall        = 1'b1;
          flush_pend_d = 1'b0;
          flush_cnt_d  = '0;
          state_d      = S_FLUSH;
        end else if (bus.wr || (bus.rd && bus.addr[0])) begin
          err  = 1'b1;
          done = 1'b1;
        end else if (bus.rd) begin
          if (|hit_vec) begin
            done        = 1'b1;
            out_en      = 1'b1;
            cache_hit_d = 1'b1;
          end else begin
            stall       = 1'b1;
            req_d       = bus.addr[ADDR_W-1:1];
            victim_d    = has_free ? free_way : rr_q[idx];
            evict_d     = ~has_free;
            issue_cnt_d = '0;
            resp_cnt_d  = '0;
            state_d     = S_FILL;
          end
        end
      end
      S_FILL: begin
        stall = 1'b1;
        if (bus.flush) flush_pend_d = 1'b1;
        mem_rd = (issue_cnt_q < CNT_W'(WORDS));
        if (mem_rd && !bus.mem_stall) issue_cnt_d = issue_cnt_q + 1'b1;
        if (bus.mem_rvalid && (resp_cnt_q < CNT_W'(WORDS))) begin
          fill_we    = 1'b1;
          resp_cnt_d = resp_cnt_q + 1'b1;
          if (resp_cnt_q == CNT_W'(WORDS - 1)) begin
            line_done = 1'b1;
            state_d   = S_RESP;
          end
        end
      end
      S_RESP: begin
        done   = 1'b1;
        out_en = 1'b1;
        if (bus.flush) flush_pend_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        stall       = 1'b1;
        flush_clr   = 1'b1;
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
      end
    endcase
  end

  logic [WAY_W-1:0] rd_way;
  assign rd_way = (state_q == S_RESP) ? victim_q : hit_way;

  assign bus.done      = done;
  assign bus.stall     = stall;
  assign bus.err       = err;
  assign bus.cache_hit = cache_hit_q;
  assign bus.data_out  = out_en ? data_mem[rd_way][idx][word] : '0;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_addr  = mem_rd ? {req_q[ADDR_W-2:WORD_W], issue_cnt_q[WORD_W-1:0], 1'b0} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      victim_q     <= '0;
      evict_q      <= 1'b0;
      issue_cnt_q  <= '0;
      resp_cnt_q   <= '0;
      flush_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
      cache_hit_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      victim_q     <= victim_d;
      evict_q      <= evict_d;
      issue_cnt_q  <= issue_cnt_d;
      resp_cnt_q   <= resp_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_pend_q <= flush_pend_d;
      cache_hit_q  <= cache_hit_d;
      if (line_done) begin
        valid_q[idx][victim_q] <= 1'b1;
        if (evict_q) rr_q[idx] <= rr_next;
      end
      if (flush_clr) begin
        valid_q[flush_cnt_q] <= '0;
        rr_q[flush_cnt_q]    <= '0;
      end
    end
  end

  // Storage arrays carry no reset; the valid bits alone gate their contents.
  always_ff @(posedge clk) begin
    if (fill_we) data_mem[victim_q][idx][resp_cnt_q[WORD_W-1:0]] <= bus.mem_rdata;
    if (line_done) tag_mem[victim_q][idx] <= tag;
  end

endmodule

`default_nettype wire
